// File: rtl/press_classifier_pkg.sv
// Shared definitions for the push-button gesture classifier: state codes,
// default thresholds and the event payload.
package press_classifier_pkg;

    localparam int unsigned LONG_CYCLES_DEF = 8;
    localparam int unsigned GAP_CYCLES_DEF  = 4;
    localparam int unsigned TW_DEF          = 4;
    localparam int unsigned STATE_W         = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRESS1 = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT2  = 3'd2;
    localparam logic [STATE_W-1:0] ST_PRESS2 = 3'd3;
    localparam logic [STATE_W-1:0] ST_HELD   = 3'd4;

    typedef struct packed {
        logic is_single;
        logic is_double;
        logic is_long;
    } press_evt_t;

endpackage

// File: rtl/press_classifier_cycle_timer.sv
// Saturating cycle counter; a clear request wins over the increment.
module press_classifier_cycle_timer #(
    parameter int unsigned TW = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Clr,
    output logic [TW-1:0] Count
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Count <= '0;
        end else if (Clr) begin
            Count <= '0;
        end else if (Count != {TW{1'b1}}) begin
            Count <= Count + TW'(1);
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into single, double and long presses,
// emitting one-cycle registered event pulses.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned TW          = TW_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Btn,
    output logic               SinglePress,
    output logic               DoublePress,
    output logic               LongPress,
    output logic [STATE_W-1:0] State
);

    if (LONG_CYCLES < 2 || LONG_CYCLES > (2**TW) - 1 ||
        GAP_CYCLES  < 2 || GAP_CYCLES  > (2**TW) - 1) begin : g_param_err
        $error("press_classifier: LONG_CYCLES/GAP_CYCLES out of range for TW");
    end

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    press_evt_t         r_evt;
    press_evt_t         w_evt;
    logic [TW-1:0]      w_count;
    logic               w_clr;
    logic               w_long_hit;
    logic               w_gap_hit;

    // Timer restarts from zero on every state change
    press_classifier_cycle_timer #(
        .TW    (TW)
    ) u_timer (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Clr   (w_clr),
        .Count (w_count)
    );

    assign w_long_hit = (w_count == TW'(LONG_CYCLES - 1));
    assign w_gap_hit  = (w_count == TW'(GAP_CYCLES - 1));
    assign w_clr      = (w_next_state != r_state);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_evt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_evt   <= w_evt;
        end
    end

    // Button edges take priority over timer thresholds on the same clock
    always_comb begin
        w_next_state = r_state;
        w_evt        = '0;
        case (r_state)
            ST_IDLE: begin
                if (Btn) begin
                    w_next_state = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (!Btn) begin
                    w_next_state = ST_WAIT2;
                end else if (w_long_hit) begin
                    w_evt.is_long = 1'b1;
                    w_next_state  = ST_HELD;
                end
            end
            ST_WAIT2: begin
                if (Btn) begin
                    w_next_state = ST_PRESS2;
                end else if (w_gap_hit) begin
                    w_evt.is_single = 1'b1;
                    w_next_state    = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (!Btn) begin
                    w_evt.is_double = 1'b1;
                    w_next_state    = ST_IDLE;
                end else if (w_long_hit) begin
                    w_evt.is_double = 1'b1;
                    w_next_state    = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!Btn) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign SinglePress = r_evt.is_single;
    assign DoublePress = r_evt.is_double;
    assign LongPress   = r_evt.is_long;
    assign State       = r_state;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: a behavioural model predicts state
// and pulses per clock; directed gestures also check pulse counts and timing.
module tb_press_classifier;

    logic       Clk;
    logic       Rst_n;
    logic       Btn;
    logic       SinglePress;
    logic       DoublePress;
    logic       LongPress;
    logic [2:0] State;

    typedef struct {
        logic [2:0] st;
        logic [2:0] pulses;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_state  = 0;
    int   m_timer  = 0;
    int   cyc      = 0;
    int   n_single = 0;
    int   n_double = 0;
    int   n_long   = 0;
    int   single_cyc = -1;

    press_classifier #(
        .LONG_CYCLES (8),
        .GAP_CYCLES  (4),
        .TW          (4)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Btn         (Btn),
        .SinglePress (SinglePress),
        .DoublePress (DoublePress),
        .LongPress   (LongPress),
        .State       (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    // Reference model: one clock of the gesture rules; pulses = {single,double,long}
    task automatic model_step(input logic b);
        int         nxt;
        logic [2:0] p;
        exp_t       e;
        nxt = m_state;
        p   = 3'b000;
        if (!Rst_n) begin
            m_state = 0;
            m_timer = 0;
        end else begin
            case (m_state)
                0: if (b) nxt = 1;
                1: begin
                    if (!b) nxt = 2;
                    else if (m_timer == 7) begin nxt = 4; p = 3'b001; end
                end
                2: begin
                    if (b) nxt = 3;
                    else if (m_timer == 3) begin nxt = 0; p = 3'b100; end
                end
                3: begin
                    if (!b) begin nxt = 0; p = 3'b010; end
                    else if (m_timer == 7) begin nxt = 4; p = 3'b010; end
                end
                default: if (!b) nxt = 0;
            endcase
            if (nxt != m_state) m_timer = 0;
            else if (m_timer < 15) m_timer++;
            m_state = nxt;
        end
        e.st     = 3'(m_state);
        e.pulses = p;
        sb.push_back(e);
    endtask

    task automatic tick(input logic b);
        exp_t e;
        logic [2:0] pl;
        Btn = b;
        cyc++;
        model_step(b);
        @(posedge Clk);
        #1;
        pl = {SinglePress, DoublePress, LongPress};
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq("state", 32'(State), 32'(e.st));
            check_eq("pulses", 32'(pl), 32'(e.pulses));
        end
        check_eq("one_pulse_max", 32'($countones(pl) <= 1), 32'd1);
        if (SinglePress) begin n_single++; single_cyc = cyc; end
        if (DoublePress) n_double++;
        if (LongPress)   n_long++;
    endtask

    task automatic ticks(input logic b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    task automatic clear_counts();
        cyc = 0; n_single = 0; n_double = 0; n_long = 0; single_cyc = -1;
    endtask

    task automatic expect_counts(input string tag, input int s, input int d, input int l);
        check_eq({tag, "_single"}, 32'(n_single), 32'(s));
        check_eq({tag, "_double"}, 32'(n_double), 32'(d));
        check_eq({tag, "_long"},   32'(n_long),   32'(l));
    endtask

    initial begin
        Rst_n = 1'b0;
        Btn   = 1'b0;

        // Reset held with the button toggling
        for (int i = 0; i < 6; i++) tick(1'(i & 1));
        check_eq("reset_state", 32'(State), 32'd0);
        Rst_n = 1'b1;
        ticks(1'b0, 2);

        // Single: high 3, low; pulse 4 clocks after the release edge
        clear_counts();
        ticks(1'b1, 3);
        ticks(1'b0, 8);
        expect_counts("single", 1, 0, 0);
        check_eq("single_latency", 32'(single_cyc), 32'd8);

        // Double
        clear_counts();
        ticks(1'b1, 2); ticks(1'b0, 2); ticks(1'b1, 2); ticks(1'b0, 8);
        expect_counts("double", 0, 1, 0);

        // Long: one pulse, HELD until release, silent release
        clear_counts();
        ticks(1'b1, 20);
        check_eq("long_held_state", 32'(State), 32'd4);
        ticks(1'b0, 6);
        expect_counts("long", 0, 0, 1);
        check_eq("long_release_state", 32'(State), 32'd0);

        // Gap reached: single, then the next press starts a new PRESS1
        clear_counts();
        ticks(1'b1, 2); ticks(1'b0, 5);
        check_eq("gap_single_now", 32'(n_single), 32'd1);
        tick(1'b1);
        check_eq("gap_new_press1", 32'(State), 32'd1);
        ticks(1'b1, 1); ticks(1'b0, 8);
        expect_counts("gap_reached", 2, 0, 0);

        // Press one clock before the gap threshold: double
        clear_counts();
        ticks(1'b1, 2); ticks(1'b0, 3); ticks(1'b1, 2); ticks(1'b0, 8);
        expect_counts("gap_short", 0, 1, 0);

        // Press on the same edge as the gap threshold: press wins
        clear_counts();
        ticks(1'b1, 2); ticks(1'b0, 4); tick(1'b1);
        check_eq("gap_tie_press2", 32'(State), 32'd3);
        ticks(1'b0, 8);
        expect_counts("gap_tie", 0, 1, 0);

        // Release on the same edge as the long threshold: release wins
        clear_counts();
        ticks(1'b1, 8); tick(1'b0);
        check_eq("long_tie_wait2", 32'(State), 32'd2);
        ticks(1'b0, 8);
        expect_counts("long_tie", 1, 0, 0);

        // Second press held long: double, then HELD
        clear_counts();
        ticks(1'b1, 2); tick(1'b0); ticks(1'b1, 12);
        check_eq("dbl_held_state", 32'(State), 32'd4);
        ticks(1'b0, 4);
        expect_counts("dbl_held", 0, 1, 0);

        // Third press after a double starts a fresh gesture
        clear_counts();
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1); ticks(1'b0, 8);
        expect_counts("third_press", 1, 1, 0);

        // Mid-gesture reset in WAIT2 discards the gesture
        clear_counts();
        ticks(1'b1, 2); ticks(1'b0, 2);
        check_eq("mid_in_wait2", 32'(State), 32'd2);
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("mid_async_state", 32'(State), 32'd0);
        check_eq("mid_async_pulses", 32'({SinglePress, DoublePress, LongPress}), 32'd0);
        m_state = 0;
        m_timer = 0;
        ticks(1'b0, 3);
        Rst_n = 1'b1;
        ticks(1'b0, 8);
        expect_counts("mid_reset", 0, 0, 0);

        // Random button runs against the model
        for (int i = 0; i < 60; i++) begin
            ticks(1'($urandom_range(0, 1)), $urandom_range(1, 10));
        end
        ticks(1'b0, 10);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
